// File: rtl/shared_pkg.sv
// rtl/shared_pkg.sv - shared FIFO sizing and write-arbiter types
// Purpose: constants and types shared by the FIFO and its write-side arbiter.
//   FIFO_WIDTH / FIFO_DEPTH : FIFO geometry reused by all FIFO-side blocks.
//   ARB_MAX_REQ / ARB_IDX_W : largest supported requester count and index width.
//   wr_arb_state_e          : write arbiter FSM states.
//   rr_next()               : round-robin successor of an index, wrapping at n-1.
package shared_pkg;

  localparam int FIFO_WIDTH  = 16;
  localparam int FIFO_DEPTH  = 8;
  localparam int ARB_MAX_REQ = 8;
  localparam int ARB_IDX_W   = $clog2(ARB_MAX_REQ);

  typedef enum logic [1:0] {ARB_IDLE, ARB_WRITE, ARB_RESP} wr_arb_state_e;

  function automatic logic [ARB_IDX_W-1:0] rr_next(input logic [ARB_IDX_W-1:0] idx,
                                                   input int n);
    return (int'(idx) == n - 1) ? '0 : idx + ARB_IDX_W'(1);
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational round-robin winner search
// Purpose: finds the first set request bit searching upward from rr_ptr,
//   wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req    in  NUM_REQ    request vector
//   rr_ptr in  ARB_IDX_W  search start index (must be < NUM_REQ)
//   found  out 1          any request set
//   winner out ARB_IDX_W  index of the winning request (0 when none)
module fifo_rr_pick
  import shared_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [ARB_IDX_W-1:0] rr_ptr,
  output logic                 found,
  output logic [ARB_IDX_W-1:0] winner
);

  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [ARB_IDX_W-1:0] w_off;
  logic [ARB_IDX_W:0]   w_sum;

  // Rotate so that bit 0 of w_rot is the requester at rr_ptr; the lowest set
  // bit of w_rot is then the distance from rr_ptr to the winner.
  assign w_req_dbl = {req, req};
  assign w_rot     = NUM_REQ'(w_req_dbl >> rr_ptr);

  always_comb begin
    found = 1'b0;
    w_off = '0;
    // Descending scan so the lowest set offset is the final assignment.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        found = 1'b1;
        w_off = ARB_IDX_W'(k);
      end
    end
  end

  assign w_sum  = {1'b0, rr_ptr} + {1'b0, w_off};
  assign winner = (w_sum >= (ARB_IDX_W+1)'(NUM_REQ))
                ? ARB_IDX_W'(w_sum - (ARB_IDX_W+1)'(NUM_REQ))
                : w_sum[ARB_IDX_W-1:0];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter for the FIFO write port
// Purpose: shares one FIFO write port between NUM_REQ producers. The winner's
//   word is latched at grant, written with a one-cycle wr_en, and the FIFO's
//   registered wr_ack/overflow comes back as a done/drop pulse. All outputs
//   are registered. Define WR_ARB_FULL_GUARD_EN to hold off grants while
//   fifo_full is high; by default grants ignore fifo_full.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req[NUM_REQ]                    per-requester level request
//   req_data[NUM_REQ*FIFO_WIDTH]    packed words, requester i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   gnt[NUM_REQ]                    one-hot grant, held through WRITE and RESP
//   done[NUM_REQ], drop[NUM_REQ]    one-cycle outcome pulses to the granted requester
//   busy                            state is not IDLE
//   proto_err                       sticky: RESP saw neither or both of wr_ack/overflow
//   fifo_wr_en, fifo_data_in        FIFO write side
//   fifo_full, fifo_wr_ack, fifo_overflow   FIFO status (ack/overflow one cycle after wr_en)
module fifo_wr_arbiter
  import shared_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            drop,
  output logic                          busy,
  output logic                          proto_err,
  output logic                          fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow
);

  wr_arb_state_e        r_state, w_state_nxt;
  logic [ARB_IDX_W-1:0] r_rr_ptr, w_ptr_nxt;
  logic [ARB_IDX_W-1:0] r_win, w_win_nxt;
  logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0]   r_done, w_done_nxt;
  logic [NUM_REQ-1:0]   r_drop, w_drop_nxt;
  logic                 r_busy;
  logic                 r_proto_err, w_perr_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic [FIFO_WIDTH-1:0] r_data, w_data_nxt;

  logic                  w_found;
  logic [ARB_IDX_W-1:0]  w_winner;
  logic [FIFO_WIDTH-1:0] w_sel_data;
  logic                  w_guard_ok;

  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .rr_ptr (r_rr_ptr),
    .found  (w_found),
    .winner (w_winner)
  );

  assign w_sel_data = FIFO_WIDTH'(req_data >> (int'(w_winner) * FIFO_WIDTH));

`ifdef WR_ARB_FULL_GUARD_EN
  assign w_guard_ok = ~fifo_full;
`else
  logic w_unused_full;
  assign w_unused_full = fifo_full;
  assign w_guard_ok    = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_rr_ptr;
    w_win_nxt   = r_win;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = '0;
    w_drop_nxt  = '0;
    w_perr_nxt  = r_proto_err;
    w_wr_en_nxt = 1'b0;
    w_data_nxt  = r_data;
    case (r_state)
      ARB_IDLE: begin
        if (w_found && w_guard_ok) begin
          w_state_nxt = ARB_WRITE;
          w_win_nxt   = w_winner;
          w_gnt_nxt   = NUM_REQ'(1) << w_winner;
          w_wr_en_nxt = 1'b1;
          w_data_nxt  = w_sel_data;
        end
      end
      ARB_WRITE: begin
        w_state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
        w_ptr_nxt   = rr_next(r_win, NUM_REQ);
        // Both flags set counts as accepted; neither set counts as lost.
        if (fifo_wr_ack) begin
          w_done_nxt = r_gnt;
        end else begin
          w_drop_nxt = r_gnt;
        end
        if (fifo_wr_ack == fifo_overflow) begin
          w_perr_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_rr_ptr    <= '0;
      r_win       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_drop      <= '0;
      r_busy      <= 1'b0;
      r_proto_err <= 1'b0;
      r_wr_en     <= 1'b0;
      r_data      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_ptr_nxt;
      r_win       <= w_win_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_drop      <= w_drop_nxt;
      r_busy      <= (w_state_nxt != ARB_IDLE);
      r_proto_err <= w_perr_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_data      <= w_data_nxt;
    end
  end

  assign gnt          = r_gnt;
  assign done         = r_done;
  assign drop         = r_drop;
  assign busy         = r_busy;
  assign proto_err    = r_proto_err;
  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  import shared_pkg::*;

  localparam int N = 4;
  localparam int W = FIFO_WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt, done, drop;
  logic             busy, proto_err, fifo_wr_en;
  logic [W-1:0]     fifo_data_in;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_ack = 1'b0;
  logic             fifo_overflow = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .done          (done),
    .drop          (drop),
    .busy          (busy),
    .proto_err     (proto_err),
    .fifo_wr_en    (fifo_wr_en),
    .fifo_data_in  (fifo_data_in),
    .fifo_full     (fifo_full),
    .fifo_wr_ack   (fifo_wr_ack),
    .fifo_overflow (fifo_overflow)
  );

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] data;
  } wexp_t;

  typedef struct {
    logic [N-1:0] who;
    logic         is_drop;
  } rexp_t;

  wexp_t      wq[$];
  rexp_t      rq[$];
  logic [W-1:0] fq[$];
  logic [W-1:0] dat [N];
  int         fmode = 0;   // 0 normal, 1 no response, 2 both ack and overflow
  logic       tb_rd = 1'b0;
  logic       tb_clr = 1'b0;
  int         errors = 0;
  int         checks = 0;

  // Behavioural FIFO write side with registered wr_ack / overflow / full.
  always @(posedge clk) begin
    fifo_wr_ack   <= 1'b0;
    fifo_overflow <= 1'b0;
    if (tb_clr) begin
      fq.delete();
    end else begin
      if (tb_rd && fq.size() != 0) begin
        void'(fq.pop_front());
      end
      if (fifo_wr_en) begin
        if (fmode == 1) begin
          fifo_wr_ack <= 1'b0;
        end else if (fmode == 2) begin
          fifo_wr_ack   <= 1'b1;
          fifo_overflow <= 1'b1;
        end else if (fq.size() < FIFO_DEPTH) begin
          fq.push_back(fifo_data_in);
          fifo_wr_ack <= 1'b1;
        end else begin
          fifo_overflow <= 1'b1;
        end
      end
    end
    fifo_full <= (fq.size() == FIFO_DEPTH);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data();
    req_data = {dat[3], dat[2], dat[1], dat[0]};
  endtask

  task automatic push(input int who, input logic is_drop);
    wexp_t we;
    rexp_t re;
    we.gnt     = N'(1) << who;
    we.data    = dat[who];
    re.who     = N'(1) << who;
    re.is_drop = is_drop;
    wq.push_back(we);
    rq.push_back(re);
  endtask

  // One clock; outputs sampled 1 time unit after the edge and matched
  // against the scoreboard queues.
  task automatic tick();
    wexp_t we;
    rexp_t re;
    @(posedge clk);
    #1;
    if (fifo_wr_en) begin
      chk("sb_wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        we = wq.pop_front();
        chk("sb_wr_gnt", 32'(gnt), 32'(we.gnt));
        chk("sb_wr_data", 32'(fifo_data_in), 32'(we.data));
      end
    end
    if ((done | drop) != '0) begin
      chk("sb_resp_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        re = rq.pop_front();
        chk("sb_resp_who", 32'(done | drop), 32'(re.who));
        chk("sb_resp_kind", 32'(drop != '0), 32'(re.is_drop));
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic clear_fifo();
    tb_clr = 1'b1;
    tick();
    tb_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < N; i++) dat[i] = '0;
    set_data();
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_perr", 32'(proto_err), 32'd0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data", 32'(fifo_data_in), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(ARB_IDLE));
    chk("rst_ptr", 32'(dut.r_rr_ptr), 32'd0);
    rst_n = 1'b1;
    clear_fifo();

    // Single requester, explicit latency.
    dat[1] = 16'hA5A5;
    set_data();
    req = 4'b0010;
    push(1, 1'b0);
    tick();
    chk("t1_wr_en", 32'(fifo_wr_en), 32'd1);
    chk("t1_data", 32'(fifo_data_in), 32'hA5A5);
    chk("t1_gnt_p1", 32'(gnt), 32'b0010);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_wr_en_off", 32'(fifo_wr_en), 32'd0);
    chk("t1_gnt_p2", 32'(gnt), 32'b0010);
    tick();
    chk("t1_done", 32'(done), 32'b0010);
    chk("t1_gnt_p3", 32'(gnt), 32'd0);
    req = '0;
    chk("t1_ptr", 32'(dut.r_rr_ptr), 32'd2);
    tick();
    chk("t1_idle", 32'(busy), 32'd0);

    // All requesters held: strict rotation from rr_ptr=0.
    do_reset();
    clear_fifo();
    dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333; dat[3] = 16'h4444;
    set_data();
    for (int n = 0; n < 8; n++) push(n % N, 1'b0);
    req = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      tick();
      tick();
      tick();
    end
    req = '0;
    tick();
    chk("t2_idle", 32'(busy), 32'd0);
    chk("t2_count", 32'(fq.size()), 32'd8);
    for (int i = 0; i < 8 && i < fq.size(); i++) chk("t2_fifo_order", 32'(fq[i]), 32'(dat[i % N]));
    chk("t2_full", 32'(fifo_full), 32'd1);
    chk("t2_ptr", 32'(dut.r_rr_ptr), 32'd0);

    // Request into a full FIFO.
    dat[0] = 16'hBEEF;
    set_data();
`ifdef WR_ARB_FULL_GUARD_EN
    req = 4'b0001;
    push(0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_gnt", 32'(gnt), 32'd0);
    end
    tb_rd = 1'b1;
    tick();
    tb_rd = 1'b0;
    chk("t4_hold_gnt_rd", 32'(gnt), 32'd0);
    tick();
    chk("t4_gnt", 32'(gnt), 32'b0001);
    tick();
    tick();
    chk("t4_done", 32'(done), 32'b0001);
    req = '0;
    chk("t4_tail", 32'(fq[fq.size()-1]), 32'hBEEF);
`else
    req = 4'b0001;
    push(0, 1'b1);
    tick();
    chk("t4_gnt", 32'(gnt), 32'b0001);
    tick();
    tick();
    chk("t4_drop", 32'(drop), 32'b0001);
    chk("t4_no_done", 32'(done), 32'd0);
    req = '0;
    chk("t4_count", 32'(fq.size()), 32'd8);
`endif
    tick();
    clear_fifo();

    // Pointer wrap: reach rr_ptr=3, then 3 wins before 0.
    dat[2] = 16'h2C2C;
    set_data();
    req = 4'b0100;
    push(2, 1'b0);
    tick(); tick(); tick();
    req = '0;
    chk("t3_ptr3", 32'(dut.r_rr_ptr), 32'd3);
    tick();
    dat[3] = 16'h3D3D; dat[0] = 16'h0A0A;
    set_data();
    req = 4'b1001;
    push(3, 1'b0);
    push(0, 1'b0);
    tick(); tick(); tick();
    chk("t3_wrap_ptr", 32'(dut.r_rr_ptr), 32'd0);
    tick(); tick(); tick();
    req = '0;
    chk("t3_ptr1", 32'(dut.r_rr_ptr), 32'd1);
    tick();

    // Reset during WRITE aborts without a done/drop.
    dat[0] = 16'h5555;
    set_data();
    begin
      wexp_t we;
      we.gnt  = 4'b0001;
      we.data = 16'h5555;
      wq.push_back(we);
    end
    req = 4'b0001;
    tick();
    chk("t5_wr_en", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_wr_en0", 32'(fifo_wr_en), 32'd0);
    chk("t5_data", 32'(fifo_data_in), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_done_drop", 32'(done | drop), 32'd0);
    chk("t5_state", 32'(dut.r_state), 32'(ARB_IDLE));
    chk("t5_ptr", 32'(dut.r_rr_ptr), 32'd0);
    rst_n = 1'b1;
    req = '0;
    for (int i = 0; i < 4; i++) tick();
    chk("t5_quiet", 32'(busy), 32'd0);
    clear_fifo();

    // Both wr_ack and overflow: done plus proto_err.
    fmode = 2;
    dat[2] = 16'h7777;
    set_data();
    req = 4'b0100;
    push(2, 1'b0);
    tick(); tick(); tick();
    chk("t6b_done", 32'(done), 32'b0100);
    chk("t6b_perr", 32'(proto_err), 32'd1);
    req = '0;
    fmode = 0;
    tick();
    do_reset();
    chk("t6b_perr_rst", 32'(proto_err), 32'd0);

    // No response at all: drop plus sticky proto_err.
    fmode = 1;
    dat[1] = 16'h6666;
    set_data();
    req = 4'b0010;
    push(1, 1'b1);
    tick(); tick(); tick();
    chk("t6_drop", 32'(drop), 32'b0010);
    chk("t6_perr", 32'(proto_err), 32'd1);
    req = '0;
    fmode = 0;
    tick(); tick(); tick();
    chk("t6_perr_sticky", 32'(proto_err), 32'd1);
    dat[3] = 16'h8888;
    set_data();
    req = 4'b1000;
    push(3, 1'b0);
    tick(); tick(); tick();
    chk("t6_done_after", 32'(done), 32'b1000);
    chk("t6_perr_still", 32'(proto_err), 32'd1);
    req = '0;
    do_reset();
    chk("t6_perr_clear", 32'(proto_err), 32'd0);

    chk("end_wq_empty", 32'(wq.size()), 32'd0);
    chk("end_rq_empty", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
